sprite_anim_ctrl: RTL and testbench

//  Character animation sequencer sitting directly upstream of the sprite ROM mux.

---
 rtl/sprite_anim_if.sv | 18 +
 rtl/sprite_anim_ctrl.sv | 153 +++++++++++++++
 tb/tb_sprite_anim_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sprite_anim_if.sv
// Movement/tick inputs and sprite_control output of the sprite animation sequencer.
interface sprite_anim_if;
  logic       frame_tick;
  logic       move_left;
  logic       move_right;
  logic       airborne;
  logic [6:0] sprite_control;

  modport master (
    output frame_tick, move_left, move_right, airborne,
    input  sprite_control
  );

  modport slave (
    input  frame_tick, move_left, move_right, airborne,
    output sprite_control
  );
endinterface

// File: rtl/sprite_anim_ctrl.sv
// Character animation sequencer: idle/run/jump FSM, facing and run-cycle stepping -> sprite_control.
// Optional SPRITE_ANIM_HOLD_EN: sprite_control only reloads on the edge after a frame_tick.
module sprite_anim_ctrl #(
  parameter int FRAMES_PER_STEP = 4,
  parameter int RUN_FRAMES      = 8,
  parameter int IDLE_DELAY      = 6
) (
  input  logic          clk,
  input  logic          rst,
  sprite_anim_if.slave  bus
);

  localparam int ST_W = $clog2(FRAMES_PER_STEP + 1);
  localparam int SP_W = (IDLE_DELAY > 0) ? $clog2(IDLE_DELAY + 1) : 1;

  localparam logic [ST_W-1:0] STEP_LAST = ST_W'(FRAMES_PER_STEP - 1);
  localparam logic [ST_W-1:0] STEP_ONE  = ST_W'(1);
  localparam logic [SP_W-1:0] STOP_LIM  = SP_W'(IDLE_DELAY);
  localparam logic [SP_W-1:0] STOP_ONE  = SP_W'(1);
  localparam logic [3:0]      IDX_LAST  = 4'(RUN_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_JUMP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            facing_q, facing_d;
  logic [3:0]      run_idx_q, run_idx_d;
  logic [ST_W-1:0] step_cnt_q, step_cnt_d;
  logic [SP_W-1:0] stop_cnt_q, stop_cnt_d;
  logic [6:0]      sprite_control_q, sprite_control_d;
  logic            moving;

  function automatic logic [6:0] encode_ctrl(input state_e st, input logic face,
                                             input logic [3:0] idx);
    return {face, (st == ST_JUMP), (st == ST_IDLE), (st == ST_RUN) ? idx : 4'd0};
  endfunction

  assign moving = bus.move_left ^ bus.move_right;

  always_comb begin
    state_d    = state_q;
    facing_d   = facing_q;
    run_idx_d  = run_idx_q;
    step_cnt_d = step_cnt_q;
    stop_cnt_d = stop_cnt_q;

    if (bus.move_right && !bus.move_left) facing_d = 1'b1;
    else if (bus.move_left && !bus.move_right) facing_d = 1'b0;

    // Every state change restarts all counters, so a coincident tick is swallowed.
    if (bus.airborne) begin
      if (state_q != ST_JUMP) begin
        state_d    = ST_JUMP;
        run_idx_d  = '0;
        step_cnt_d = '0;
        stop_cnt_d = '0;
      end
    end else begin
      case (state_q)
        ST_JUMP: begin
          state_d    = moving ? ST_RUN : ST_IDLE;
          run_idx_d  = '0;
          step_cnt_d = '0;
          stop_cnt_d = '0;
        end
        ST_IDLE: begin
          if (moving) begin
            state_d    = ST_RUN;
            run_idx_d  = '0;
            step_cnt_d = '0;
            stop_cnt_d = '0;
          end
        end
        ST_RUN: begin
          if (moving) begin
            stop_cnt_d = '0;
            if (bus.frame_tick) begin
              if (step_cnt_q == STEP_LAST) begin
                step_cnt_d = '0;
                run_idx_d  = (run_idx_q == IDX_LAST) ? 4'd0 : run_idx_q + 4'd1;
              end else begin
                step_cnt_d = step_cnt_q + STEP_ONE;
              end
            end
          end else if (IDLE_DELAY == 0) begin
            state_d    = ST_IDLE;
            run_idx_d  = '0;
            step_cnt_d = '0;
            stop_cnt_d = '0;
          end else if (bus.frame_tick) begin
            if (stop_cnt_q + STOP_ONE == STOP_LIM) begin
              state_d    = ST_IDLE;
              run_idx_d  = '0;
              step_cnt_d = '0;
              stop_cnt_d = '0;
            end else begin
              stop_cnt_d = stop_cnt_q + STOP_ONE;
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          run_idx_d  = '0;
          step_cnt_d = '0;
          stop_cnt_d = '0;
        end
      endcase
    end
  end

`ifdef SPRITE_ANIM_HOLD_EN
  logic tick_q;

  always_ff @(posedge clk) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= bus.frame_tick;
  end

  // Reload once per video frame so the sprite never switches mid-frame.
  always_comb begin
    sprite_control_d = sprite_control_q;
    if (tick_q) sprite_control_d = encode_ctrl(state_q, facing_q, run_idx_q);
  end
`else
  always_comb begin
    sprite_control_d = encode_ctrl(state_q, facing_q, run_idx_q);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      facing_q         <= 1'b1;
      run_idx_q        <= '0;
      step_cnt_q       <= '0;
      stop_cnt_q       <= '0;
      sprite_control_q <= 7'h50;
    end else begin
      state_q          <= state_d;
      facing_q         <= facing_d;
      run_idx_q        <= run_idx_d;
      step_cnt_q       <= step_cnt_d;
      stop_cnt_q       <= stop_cnt_d;
      sprite_control_q <= sprite_control_d;
    end
  end

  assign bus.sprite_control = sprite_control_q;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed bench for sprite_anim_ctrl with default parameters (4 frames/step, 8 run frames, idle delay 6).
module tb_sprite_anim_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  sprite_anim_if bus ();

  sprite_anim_ctrl #(
    .FRAMES_PER_STEP (4),
    .RUN_FRAMES      (8),
    .IDLE_DELAY      (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 7'h%02h, expected 7'h%02h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      @(posedge clk);
      #1;
      bus.frame_tick = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    bus.frame_tick = 1'b0;
    bus.move_left  = 1'b0;
    bus.move_right = 1'b0;
    bus.airborne   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear_inputs();

    // Reset with arbitrary inputs driven
    rst            = 1'b1;
    bus.frame_tick = 1'($urandom);
    bus.move_left  = 1'b1;
    bus.move_right = 1'b0;
    bus.airborne   = 1'b1;
    cyc(2);
    chk("reset_value", bus.sprite_control, 7'h50);
    clear_inputs();
    rst = 1'b0;
    cyc(2);
    chk("idle_after_reset", bus.sprite_control, 7'h50);

`ifdef SPRITE_ANIM_HOLD_EN
    do_reset();
    cyc(3);
    bus.move_right = 1'b1;
    cyc(4);
    chk("hold_midframe", bus.sprite_control, 7'h50);
    tick(1);
    chk("hold_tick_edge", bus.sprite_control, 7'h50);
    cyc(1);
    chk("hold_reload_run", bus.sprite_control, 7'h40);
    bus.airborne = 1'b1;
    cyc(3);
    chk("hold_jump_masked", bus.sprite_control, 7'h40);
    tick(1);
    cyc(1);
    chk("hold_reload_jump", bus.sprite_control, 7'h60);
`else
    // Reset mid-run at idx 5
    do_reset();
    bus.move_right = 1'b1;
    cyc(1);
    tick(20);
    cyc(1);
    chk("run_idx5", bus.sprite_control, 7'h45);
    rst = 1'b1;
    cyc(1);
    chk("reset_midrun", bus.sprite_control, 7'h50);
    cyc(1);
    rst = 1'b0;
    clear_inputs();

    // Run right: stepping and wrap
    do_reset();
    bus.move_right = 1'b1;
    cyc(2);
    chk("run_start", bus.sprite_control, 7'h40);
    tick(3);
    cyc(1);
    chk("run_3ticks", bus.sprite_control, 7'h40);
    tick(1);
    cyc(1);
    chk("run_step1", bus.sprite_control, 7'h41);
    tick(24);
    cyc(1);
    chk("run_idx7", bus.sprite_control, 7'h47);
    tick(4);
    cyc(1);
    chk("run_wrap", bus.sprite_control, 7'h40);

    // Run left, release, idle delay
    do_reset();
    bus.move_left = 1'b1;
    cyc(2);
    chk("run_left", bus.sprite_control, 7'h00);
    tick(4);
    cyc(1);
    chk("run_left_step", bus.sprite_control, 7'h01);
    bus.move_left = 1'b0;
    cyc(2);
    chk("release_no_tick", bus.sprite_control, 7'h01);
    tick(3);
    bus.move_left = 1'b1;
    cyc(1);
    bus.move_left = 1'b0;
    tick(5);
    cyc(1);
    chk("stop_cnt_cleared", bus.sprite_control, 7'h01);
    tick(1);
    cyc(1);
    chk("idle_after_delay", bus.sprite_control, 7'h10);

    // Jump from run at idx 3, land while still moving
    do_reset();
    bus.move_right = 1'b1;
    cyc(1);
    tick(12);
    cyc(1);
    chk("run_idx3", bus.sprite_control, 7'h43);
    bus.airborne = 1'b1;
    cyc(2);
    chk("jump", bus.sprite_control, 7'h60);
    bus.airborne = 1'b0;
    cyc(1);
    chk("land_latency", bus.sprite_control, 7'h60);
    cyc(1);
    chk("land_run_idx0", bus.sprite_control, 7'h40);

    // Both directions pressed: not moving
    do_reset();
    bus.move_left  = 1'b1;
    bus.move_right = 1'b1;
    cyc(2);
    chk("both_pressed", bus.sprite_control, 7'h50);
    tick(8);
    cyc(1);
    chk("both_ticks", bus.sprite_control, 7'h50);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
